// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a single-port memory.
// Data has priority; fetch is forced after STARVE_LIMIT consecutive data wins and transactions time out after TIMEOUT busy cycles.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        busy
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, RESP} state_t;

  state_t        state, next_state;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic          starve_max, wait_max;
  logic          grant_d, grant_f, ack_done, time_out;

  assign starve_max = (starve_cnt == SW'(STARVE_LIMIT));
  assign wait_max   = (wait_cnt == WW'(TIMEOUT - 1));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // A pending ack always beats the timeout in the same cycle.
  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_f    = 1'b0;
    ack_done   = 1'b0;
    time_out   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(if_req && starve_max)) begin
          grant_d    = 1'b1;
          next_state = D_BUSY;
        end else if (if_req) begin
          grant_f    = 1'b1;
          next_state = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ack) begin
          ack_done   = 1'b1;
          next_state = RESP;
        end else if (wait_max) begin
          time_out   = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      bus_err    <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      bus_err  <= 1'b0;

      if (grant_d) begin
        mem_en    <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        wait_cnt  <= '0;
        if (if_req && !starve_max) starve_cnt <= starve_cnt + 1'b1;
      end

      if (grant_f) begin
        mem_en     <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        wait_cnt   <= '0;
        starve_cnt <= '0;
      end

      // Completion (ack or timeout) raises the owner's ready for the single RESP cycle.
      if (ack_done || time_out) begin
        mem_en  <= 1'b0;
        bus_err <= time_out;
        if (state == IF_BUSY) begin
          if_ready <= 1'b1;
          if (ack_done) if_rdata <= mem_rdata;
        end else begin
          d_ready <= 1'b1;
          if (ack_done && !mem_we) d_rdata <= mem_rdata;
        end
      end else if (state == IF_BUSY || state == D_BUSY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_LIMIT(3), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({mem_en, mem_we, if_ready, d_ready, bus_err, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", {mem_en, mem_we, if_ready, d_ready, bus_err, busy}, 6'b0);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_cmd: got %h expected %h", {mem_addr, mem_wdata}, 64'h0);
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h expected %h", {if_rdata, d_rdata}, 64'h0);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_hold: got busy=%b mem_en=%b expected 0 0", busy, mem_en);
    end
  endtask

  task automatic test_fetch_read();
    if_req  = 1'b1;
    if_addr = 32'h40;
    d_we    = 1'b1;
    d_wdata = 32'hFFFF_FFFF;
    tick();
    checks++;
    if ({busy, mem_en, mem_we} !== 3'b110 || mem_addr !== 32'h40 || mem_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL fetch_cmd: got en=%b we=%b addr=%h wdata=%h expected 1 0 00000040 00000000", mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (mem_en !== 1'b1 || if_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_hold: got en=%b if_ready=%b expected 1 0", mem_en, if_ready);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h0010_0093;
    tick();
    checks++;
    if ({if_ready, d_ready, bus_err, mem_en} !== 4'b1000 || if_rdata !== 32'h0010_0093) begin
      errors++;
      $display("[TB] FAIL fetch_resp: got rdy=%b drdy=%b err=%b en=%b rdata=%h expected 1 0 0 0 00100093", if_ready, d_ready, bus_err, mem_en, if_rdata);
    end
    idle_inputs();
    tick();
    checks++;
    if (busy !== 1'b0 || if_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_done: got busy=%b if_ready=%b expected 0 0", busy, if_ready);
    end
  endtask

  task automatic test_priority();
    if_req    = 1'b1;
    if_addr   = 32'h44;
    d_req     = 1'b1;
    d_addr    = 32'h0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h4;
    tick();
    checks++;
    if (mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prio_first: got addr=%h we=%b en=%b expected 00000000 0 1", mem_addr, mem_we, mem_en);
    end
    tick();
    checks++;
    if (d_ready !== 1'b1 || if_ready !== 1'b0 || d_rdata !== 32'h4) begin
      errors++;
      $display("[TB] FAIL prio_dresp: got drdy=%b irdy=%b drdata=%h expected 1 0 00000004", d_ready, if_ready, d_rdata);
    end
    d_req     = 1'b0;
    mem_rdata = 32'h1234;
    tick();
    checks++;
    if (busy !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_gap: got busy=%b drdy=%b expected 0 0", busy, d_ready);
    end
    tick();
    checks++;
    if (mem_addr !== 32'h44 || mem_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prio_second: got addr=%h en=%b expected 00000044 1", mem_addr, mem_en);
    end
    tick();
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h1234 || d_rdata !== 32'h4) begin
      errors++;
      $display("[TB] FAIL prio_fresp: got irdy=%b irdata=%h drdata=%h expected 1 00001234 00000004", if_ready, if_rdata, d_rdata);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    logic [7:0] seq;
    int         n;
    int         both;
    seq  = '0;
    n    = 0;
    both = 0;
    if_req    = 1'b1;
    if_addr   = 32'h100;
    d_req     = 1'b1;
    d_addr    = 32'h200;
    mem_ack   = 1'b1;
    mem_rdata = 32'hAAAA_0001;
    for (int i = 0; i < 60 && n < 8; i++) begin
      tick();
      if (if_ready && d_ready) both++;
      if (d_ready) begin
        seq = {seq[6:0], 1'b1};
        n++;
      end else if (if_ready) begin
        seq = {seq[6:0], 1'b0};
        n++;
      end
    end
    idle_inputs();
    checks++;
    if (n !== 8) begin
      errors++;
      $display("[TB] FAIL starve_count: got %0d grants expected 8", n);
    end
    checks++;
    if (seq !== 8'b1110_1110) begin
      errors++;
      $display("[TB] FAIL starve_order: got %b expected %b (1=D 0=F)", seq, 8'b1110_1110);
    end
    checks++;
    if (both !== 0) begin
      errors++;
      $display("[TB] FAIL ready_exclusive: got %0d overlaps expected 0", both);
    end
    tick();
  endtask

  task automatic test_store();
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h8;
    d_wdata   = 32'h3;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h3 || mem_addr !== 32'h8) begin
      errors++;
      $display("[TB] FAIL store_cmd: got we=%b wdata=%h addr=%h expected 1 00000003 00000008", mem_we, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    checks++;
    if (d_ready !== 1'b1 || d_rdata !== 32'hAAAA_0001 || bus_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL store_resp: got drdy=%b drdata=%h err=%b expected 1 aaaa0001 0", d_ready, d_rdata, bus_err);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_drop_req();
    if_req  = 1'b1;
    if_addr = 32'h80;
    tick();
    if_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h80) begin
      errors++;
      $display("[TB] FAIL drop_hold: got busy=%b en=%b addr=%h expected 1 1 00000080", busy, mem_en, mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h99;
    tick();
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h99) begin
      errors++;
      $display("[TB] FAIL drop_resp: got irdy=%b irdata=%h expected 1 00000099", if_ready, if_rdata);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int en_cycles;
    bit seen;
    en_cycles = 0;
    seen      = 1'b0;
    d_req     = 1'b1;
    d_addr    = 32'h10;
    mem_rdata = 32'h1111_2222;
    tick();
    for (int i = 0; i < 40 && !seen; i++) begin
      if (d_ready) seen = 1'b1;
      else begin
        if (mem_en) en_cycles++;
        tick();
      end
    end
    checks++;
    if (!seen || en_cycles !== 16) begin
      errors++;
      $display("[TB] FAIL timeout_len: got seen=%b en_cycles=%0d expected 1 16", seen, en_cycles);
    end
    checks++;
    if (bus_err !== 1'b1 || mem_en !== 1'b0 || d_rdata !== 32'hAAAA_0001) begin
      errors++;
      $display("[TB] FAIL timeout_resp: got err=%b en=%b drdata=%h expected 1 0 aaaa0001", bus_err, mem_en, d_rdata);
    end
    idle_inputs();
    tick();
    checks++;
    if (busy !== 1'b0 || bus_err !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_after: got busy=%b err=%b drdy=%b expected 0 0 0", busy, bus_err, d_ready);
    end
  endtask

  task automatic test_ack_at_timeout();
    d_req     = 1'b1;
    d_addr    = 32'h14;
    mem_rdata = 32'h5555;
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (mem_en !== 1'b1 || d_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL late_ack_wait: got en=%b drdy=%b expected 1 0", mem_en, d_ready);
    end
    mem_ack = 1'b1;
    tick();
    checks++;
    if (d_ready !== 1'b1 || bus_err !== 1'b0 || d_rdata !== 32'h5555) begin
      errors++;
      $display("[TB] FAIL late_ack_resp: got drdy=%b err=%b drdata=%h expected 1 0 00005555", d_ready, bus_err, d_rdata);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int pulses;
    pulses = 0;
    d_req  = 1'b1;
    d_addr = 32'h18;
    tick();
    reset   = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b1;
    tick();
    checks++;
    if ({mem_en, mem_we, if_ready, d_ready, bus_err, busy} !== 6'b0 || {mem_addr, d_rdata, if_rdata} !== 96'h0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: got ctrl=%b addr=%h drdata=%h irdata=%h expected all 0", {mem_en, mem_we, if_ready, d_ready, bus_err, busy}, mem_addr, d_rdata, if_rdata);
    end
    reset   = 1'b1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (d_ready || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_silent: got %0d active cycles expected 0", pulses);
    end
    d_req     = 1'b1;
    d_addr    = 32'h20;
    mem_ack   = 1'b1;
    mem_rdata = 32'h77;
    tick();
    checks++;
    if (mem_addr !== 32'h20 || mem_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL postreset_cmd: got addr=%h en=%b expected 00000020 1", mem_addr, mem_en);
    end
    tick();
    checks++;
    if (d_ready !== 1'b1 || d_rdata !== 32'h77) begin
      errors++;
      $display("[TB] FAIL postreset_resp: got drdy=%b drdata=%h expected 1 00000077", d_ready, d_rdata);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_fetch_read();
    test_priority();
    test_starvation();
    test_store();
    test_drop_req();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive data wins while fetch is waiting before fetch is forced.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum busy cycles to wait for mem_ack.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports if_req in 1, if_addr in 32: instruction-fetch read request and address.
REQ-006 SHALL have ports if_ready out 1, if_rdata out 32: fetch completion pulse and read data.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32: data request, write enable, address and store data.
REQ-008 SHALL have ports d_ready out 1, d_rdata out 32: data completion pulse and load data.
REQ-009 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32: single-port memory command.
REQ-010 SHALL have ports mem_ack in 1, mem_rdata in 32: memory completion and read data, valid in the ack cycle.
REQ-011 SHALL have ports bus_err out 1 (timeout flag, coincident with the ready pulse) and busy out 1 (state != IDLE).

Function
REQ-012 SHALL implement the FSM states IDLE, IF_BUSY, D_BUSY and RESP.
REQ-013 IDLE with no request SHALL hold IDLE.
REQ-014 IDLE with a request SHALL, at that edge, enter *_BUSY, register mem_en=1, and latch addr, we and wdata from the winner into mem_addr, mem_we and mem_wdata.
REQ-015 Priority SHALL be data over fetch, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-016 starve_cnt SHALL increment when data wins while if_req=1, clear when fetch wins, and saturate at STARVE_LIMIT.
REQ-017 Fetch grants SHALL force mem_we=0 and mem_wdata=0.
REQ-018 In *_BUSY, mem_en, mem_we, mem_addr and mem_wdata SHALL be held stable until the mem_ack cycle.
REQ-019 A mem_ack cycle SHALL, at that edge, clear mem_en and enter RESP.
REQ-020 A mem_ack read SHALL register the owner's rdata from mem_rdata; a write SHALL leave d_rdata unchanged.
REQ-021 The RESP cycle SHALL pulse exactly one owner's ready for one cycle, then return to IDLE. Minimum transaction is req-to-ready = 3 cycles (ack in the first busy cycle).
REQ-022 wait_cnt SHALL clear on grant and increment each *_BUSY cycle without mem_ack.
REQ-023 If wait_cnt reaches TIMEOUT-1 with no ack, the FSM SHALL enter RESP with bus_err=1, mem_en=0 and rdata unchanged.
REQ-024 mem_ack in the same cycle as timeout SHALL win: normal completion, bus_err=0.
REQ-025 mem_ack in IDLE or RESP SHALL be ignored.
REQ-026 Dropping req mid-busy SHALL NOT abort the transaction; the ready pulse is still issued.
REQ-027 Requesters SHALL hold req, addr and data stable until ready; a req still high in RESP SHALL be re-arbitrated in the following IDLE cycle.
REQ-028 if_ready and d_ready SHALL never both be 1; mem_en SHALL never be 1 in IDLE or RESP.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE, and clear mem_en, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata, bus_err, busy, starve_cnt and wait_cnt to 0.
REQ-030 Reset mid-transaction SHALL drop the transaction silently: no ready pulse after reset.
REQ-031 The first arbitration SHALL occur in the first cycle with reset=1.

Verification
REQ-032 Fetch read: if_req=1, if_addr=0x40; mem_ack two cycles after mem_en rises, mem_rdata=0x00100093 -> mem_addr=0x40, if_ready one cycle, if_rdata=0x00100093, bus_err=0.
REQ-033 Simultaneous if_req (0x44) and d_req read (0x0, mem_rdata=0x4) -> data served first (d_rdata=0x4), then fetch of 0x44.
REQ-034 Starvation: both requests held high, ack immediate, STARVE_LIMIT=3 -> grant order D,D,D,F,D,D,D,F.
REQ-035 Store: d_we=1, d_addr=0x8, d_wdata=0x3 -> mem_we=1, mem_wdata=0x3, d_ready pulse, d_rdata unchanged.
REQ-036 Timeout: d_req, mem_ack never asserted -> mem_en high 16 cycles, then d_ready=1 and bus_err=1 in the same cycle, then busy=0.
REQ-037 Reset mid-busy: reset=0 during D_BUSY -> next cycle all outputs 0, no d_ready pulse; the next request after reset=1 is served normally.
